// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// Holds op codes, FSM states and default widths.
// Imported by the controller and the iteration datapath.
package muldiv_pkg;

  localparam int MD_W     = 32;
  localparam int MD_CNT_W = 5;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MFHI  = 3'b100;
  localparam logic [2:0] MD_MFLO  = 3'b101;
  localparam logic [2:0] MD_MTHI  = 3'b110;
  localparam logic [2:0] MD_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide on magnitudes.
// Latency: one step per cycle while step is high; load initialises from a_in/b_in.
// No backpressure of its own; the controller decides when to load and step.
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic [2*W-1:0] prod,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rem
);

  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic         div_mode;
  logic [2*W:0] p;
  logic [W:0]   r;
  logic [W-1:0] q;

  logic [W:0]   sum;
  logic [2*W:0] p_next;
  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // One step of each algorithm; P[2W] and R[W] stay zero so the sums never overflow
  always_comb begin
    sum     = p[2*W:W] + {1'b0, a_reg};
    p_next  = p[0] ? {1'b0, sum, p[W-1:1]} : {1'b0, p[2*W:1]};
    shifted = {r, q[W-1]};
    trial   = shifted - {2'b00, b_reg};
  end

  // Operand capture on load, then advance only the datapath that matches the op
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg    <= '0;
      b_reg    <= '0;
      div_mode <= 1'b0;
      p        <= '0;
      r        <= '0;
      q        <= '0;
    end else if (load) begin
      a_reg    <= a_in;
      b_reg    <= b_in;
      div_mode <= is_div;
      p        <= {{(W+1){1'b0}}, b_in};
      r        <= '0;
      q        <= a_in;
    end else if (step) begin
      if (div_mode) begin
        r <= trial[W+1] ? shifted[W:0] : trial[W:0];
        q <= {q[W-2:0], ~trial[W+1]};
      end else begin
        p <= p_next;
      end
    end
  end

  assign prod = p[2*W-1:0];
  assign quot = q;
  assign rem  = r[W-1:0];

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO owner and controller for MULT/DIV/MFHI/MFLO/MTHI/MTLO beside EX.
// Latency: 32 RUN cycles + 1 FIX cycle; HI/LO visible the cycle after FIX.
// Any muldiv op presented while busy raises Stall_MD until the sequencer is idle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int W     = MD_W,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         MdValid_ID,
  input  logic [2:0]   MdOp_ID,
  input  logic [W-1:0] SrcA_ID,
  input  logic [W-1:0] SrcB_ID,
  input  logic         HoldExt,
  output logic [W-1:0] MdResult_EX,
  output logic         Stall_MD,
  output logic         Busy,
  output logic [W-1:0] Hi,
  output logic [W-1:0] Lo
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic             neg_res;
  logic             neg_rem;

  logic             accept;
  logic             is_arith;
  logic             is_signed;
  logic             is_div;
  logic             div0;
  logic             a_neg;
  logic             b_neg;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;

  logic [2*W-1:0]   prod;
  logic [W-1:0]     quot;
  logic [W-1:0]     rem;
  logic [2*W-1:0]   prod_fix;

  // Stall ignores HoldExt so the core's stall OR cannot loop back through us
  assign Stall_MD = MdValid_ID && (state != S_IDLE);
  assign Busy     = (state != S_IDLE);
  assign accept   = MdValid_ID && !HoldExt && !Stall_MD;

  // Op decode and magnitude formation; a zero divisor keeps the raw dividend so HI returns it
  always_comb begin
    is_arith  = !MdOp_ID[2];
    is_signed = !MdOp_ID[0];
    is_div    = MdOp_ID[1];
    div0      = is_div && (SrcB_ID == '0);
    a_neg     = is_signed && SrcA_ID[W-1] && !div0;
    b_neg     = is_signed && SrcB_ID[W-1];
    a_mag     = a_neg ? -SrcA_ID : SrcA_ID;
    b_mag     = b_neg ? -SrcB_ID : SrcB_ID;
    prod_fix  = neg_res ? -prod : prod;
  end

  // HI/LO read port: only an accepted MFHI/MFLO drives a value
  always_comb begin
    MdResult_EX = '0;
    if (accept && (MdOp_ID == MD_MFHI)) begin
      MdResult_EX = Hi;
    end else if (accept && (MdOp_ID == MD_MFLO)) begin
      MdResult_EX = Lo;
    end
  end

  muldiv_iter #(.W(W)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept && is_arith),
    .step   (state == S_RUN),
    .is_div (is_div),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .prod   (prod),
    .quot   (quot),
    .rem    (rem)
  );

  // Sequencer FSM: accept in IDLE, count 32 steps in RUN, sign-fix and write HI/LO in FIX
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      Hi      <= '0;
      Lo      <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_arith) begin
              op_div  <= is_div;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= is_div && a_neg;
              cnt     <= '0;
              state   <= S_RUN;
            end else if (MdOp_ID == MD_MTHI) begin
              Hi <= SrcA_ID;
            end else if (MdOp_ID == MD_MTLO) begin
              Lo <= SrcA_ID;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == {CNT_W{1'b1}}) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (op_div) begin
            Lo <= neg_res ? -quot : quot;
            Hi <= neg_rem ? -rem : rem;
          end else begin
            Hi <= prod_fix[2*W-1:W];
            Lo <= prod_fix[W-1:0];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
